rsmp_frame_ctrl: RTL and testbench

- Frame-level sequencer for the polyphase resampler (interpolate by I, decimate by D).
- Once the input buffer signals a full frame, it issues one FIR start per output sample, with polyphase index and input base address.
- After each FIR, it waits for the FIR to finish, then writes the result to the output buffer, respecting output backpressure.
- After the last output it runs the overlap-copy phase, then pulses frame completion.
- Sits between the input-buffer address logic, the FIR engine and the output buffer.

---
 rtl/rsmp_pkg.sv | 20 ++
 rtl/rsmp_phase_acc.sv | 85 ++++++++
 rtl/rsmp_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_rsmp_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsmp_pkg.sv
// rsmp_pkg: shared types and constants for the polyphase resampler.
// Frame FSM state enum and the rate constants shared with the input buffer.
package rsmp_pkg;

  localparam int RSMP_I       = 3;
  localparam int RSMP_D       = 4;
  localparam int RSMP_N_OUT   = 576;
  localparam int RSMP_OVERLAP = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_STEP,
    S_COPY,
    S_DONE
  } state_e;

endpackage

// File: rtl/rsmp_phase_acc.sv
// rsmp_phase_acc: polyphase phase/base accumulator stepped once per output.
// Ports: clr zeroes phase/base; start begins a step; run high while stepping;
// done pulses on the exit cycle; phase/base are the registered FIR controls.
module rsmp_phase_acc
  import rsmp_pkg::*;
#(
  parameter int I    = RSMP_I,
  parameter int D    = RSMP_D,
  parameter int PH_W = 2,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            start,
  output logic            run,
  output logic            done,
  output logic [PH_W-1:0] phase,
  output logic [AW-1:0]   base
);

  localparam int TW = PH_W + 4;
  localparam logic [TW-1:0] I_T = TW'(I);
  localparam logic [TW-1:0] D_T = TW'(D);

  logic [TW-1:0]   tmp_q, tmp_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [AW-1:0]   base_q, base_d;
  logic            run_q, run_d;
  logic [TW-1:0]   sum, dif;

  assign sum = TW'(ph_q) + D_T;
  assign dif = tmp_q - I_T;

  // The exit test looks at the post-subtract value so the step
  // finishes on the same cycle as its last subtraction.
  always_comb begin
    tmp_d  = tmp_q;
    ph_d   = ph_q;
    base_d = base_q;
    run_d  = run_q;
    done   = 1'b0;
    if (clr) begin
      tmp_d  = '0;
      ph_d   = '0;
      base_d = '0;
      run_d  = 1'b0;
    end else if (run_q) begin
      tmp_d  = dif;
      base_d = base_q + 1'b1;
      if (dif < I_T) begin
        ph_d  = dif[PH_W-1:0];
        run_d = 1'b0;
        done  = 1'b1;
      end
    end else if (start) begin
      if (sum < I_T) begin
        ph_d = sum[PH_W-1:0];
        done = 1'b1;
      end else begin
        tmp_d = sum;
        run_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmp_q  <= '0;
      ph_q   <= '0;
      base_q <= '0;
      run_q  <= 1'b0;
    end else begin
      tmp_q  <= tmp_d;
      ph_q   <= ph_d;
      base_q <= base_d;
      run_q  <= run_d;
    end
  end

  assign run   = run_q;
  assign phase = ph_q;
  assign base  = base_q;

endmodule

// File: rtl/rsmp_frame_ctrl.sv
// rsmp_frame_ctrl: frame sequencer for the polyphase resampler.
// Ports: process_start kicks a frame; fir_start/phase/base drive the FIR,
// fir_done returns; out_wr/out_ready write results; out_count counts them;
// in_copy/in_copy_end run the overlap copy; frame_done ends it; busy != IDLE.
// Option RSMP_OVERRUN_DET_EN adds a sticky overrun output.
module rsmp_frame_ctrl
  import rsmp_pkg::*;
#(
  parameter int I     = RSMP_I,
  parameter int D     = RSMP_D,
  parameter int N_OUT = RSMP_N_OUT,
  parameter int PH_W  = 2,
  parameter int AW    = 10
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            process_start,
  output logic            fir_start,
  output logic [PH_W-1:0] fir_phase,
  output logic [AW-1:0]   fir_base,
  input  logic            fir_done,
  output logic            out_wr,
  input  logic            out_ready,
  output logic [AW-1:0]   out_count,
  output logic            in_copy,
  input  logic            in_copy_end,
  output logic            frame_done,
`ifdef RSMP_OVERRUN_DET_EN
  output logic            overrun,
`endif
  output logic            busy
);

  localparam logic [AW-1:0] N_LAST = AW'(N_OUT);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          st_q, st_d;
  logic          wr_q, wr_d;
  logic          cp_q, cp_d;
  logic          fd_q, fd_d;
  logic          busy_q, busy_d;
  logic          acc_clr, acc_start;
  logic          acc_run, acc_done;

  rsmp_phase_acc #(
    .I(I), .D(D), .PH_W(PH_W), .AW(AW)
  ) u_acc (
    .clk   (sys_clk),
    .rst_n (reset),
    .clr   (acc_clr),
    .start (acc_start),
    .run   (acc_run),
    .done  (acc_done),
    .phase (fir_phase),
    .base  (fir_base)
  );

  // Strobes are registered from the next state so they line up
  // exactly with the state they belong to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_clr   = 1'b0;
    acc_start = 1'b0;
    unique case (state_q)
      S_IDLE: if (process_start) begin
        state_d = S_ISSUE;
        cnt_d   = '0;
        acc_clr = 1'b1;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fir_done) state_d = S_WRITE;
      S_WRITE: if (out_ready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_STEP;
      end
      S_STEP: begin
        acc_start = !acc_run;
        if (acc_done)
          state_d = (cnt_q == N_LAST) ? S_COPY : S_ISSUE;
      end
      S_COPY:  if (in_copy_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    st_d   = (state_d == S_ISSUE);
    wr_d   = (state_d == S_WRITE);
    cp_d   = (state_d == S_COPY);
    fd_d   = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      wr_q    <= 1'b0;
      cp_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      wr_q    <= wr_d;
      cp_q    <= cp_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign fir_start  = st_q;
  assign out_wr     = wr_q;
  assign out_count  = cnt_q;
  assign in_copy    = cp_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

`ifdef RSMP_OVERRUN_DET_EN
  logic ovr_q, ovr_d;

  // A start in IDLE clears the flag; one while busy sets it.
  always_comb begin
    ovr_d = ovr_q;
    if (process_start) ovr_d = (state_q != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_rsmp_frame_ctrl.sv
// tb_rsmp_frame_ctrl: scoreboard bench for rsmp_frame_ctrl.
// Random FIR latency / output backpressure against a closed-form model.
module tb_rsmp_frame_ctrl;

  localparam int I  = 3;
  localparam int D  = 4;
  localparam int N  = 576;
  localparam int PW = 2;
  localparam int AW = 10;

  logic sys_clk = 1'b0;
  logic reset = 1'b0;
  logic process_start = 1'b0;
  logic fir_done = 1'b0;
  logic out_ready = 1'b0;
  logic in_copy_end = 1'b0;
  logic fir_start, out_wr, in_copy, frame_done, busy;
  logic [PW-1:0] fir_phase;
  logic [AW-1:0] fir_base, out_count;
`ifdef RSMP_OVERRUN_DET_EN
  logic overrun;
`endif

  rsmp_frame_ctrl dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .process_start (process_start),
    .fir_start     (fir_start),
    .fir_phase     (fir_phase),
    .fir_base      (fir_base),
    .fir_done      (fir_done),
    .out_wr        (out_wr),
    .out_ready     (out_ready),
    .out_count     (out_count),
    .in_copy       (in_copy),
    .in_copy_end   (in_copy_end),
    .frame_done    (frame_done),
`ifdef RSMP_OVERRUN_DET_EN
    .overrun       (overrun),
`endif
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int k;
    int ph;
    int base;
  } fir_t;

  fir_t exp_fir[$];
  int   exp_cnt[$];
  int   exp_done[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int frames = 0;
  int lat_fix = 5;
  bit rdy_all = 1'b1;
  bit gap_en = 1'b0;
  int bp_req_n = 0;
  int bp_used = 0;
  int bp_go_n = 0;
  int bp_seen = 0;
  int bp_cnt = 0;
  int bp_done_n = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s: got event, want none", nm);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_fir_start"}, fir_start, 0);
    chk({p, "_fir_phase"}, fir_phase, 0);
    chk({p, "_fir_base"}, fir_base, 0);
    chk({p, "_out_wr"}, out_wr, 0);
    chk({p, "_out_count"}, out_count, 0);
    chk({p, "_in_copy"}, in_copy, 0);
    chk({p, "_frame_done"}, frame_done, 0);
    chk({p, "_busy"}, busy, 0);
`ifdef RSMP_OVERRUN_DET_EN
    chk({p, "_overrun"}, overrun, 0);
`endif
  endtask

  // Reference: output k uses phase (k*D) mod I, base floor(k*D/I).
  task automatic start_frame();
    fir_t e;
    @(posedge sys_clk);
    #1 process_start = 1'b1;
    for (int k = 0; k < N; k++) begin
      e.k = k;
      e.ph = (k * D) % I;
      e.base = ((k * D) / I) % (1 << AW);
      exp_fir.push_back(e);
      exp_cnt.push_back(k);
    end
    exp_done.push_back(1);
    @(posedge sys_clk);
    #1 process_start = 1'b0;
  endtask

  task automatic wait_frame(input int tgt);
    for (int c = 0; c < 12000 && frames < tgt; c++)
      @(posedge sys_clk);
    if (frames < tgt) begin
      bad("frame_timeout");
      finish_run();
    end
  endtask

  task automatic wait_start();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge sys_clk);
      got = fir_start;
    end
    if (!got) begin
      bad("start_timeout");
      finish_run();
    end
  endtask

  task automatic post_checks();
    @(negedge sys_clk);
    chk("idle_busy", busy, 0);
    chk("idle_count_hold", out_count, N);
    chk("idle_done_low", frame_done, 0);
  endtask

  // FIR engine model
  initial begin
    int lat;
    forever begin
      @(negedge sys_clk);
      if (reset && fir_start) begin
        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
        repeat (lat) @(posedge sys_clk);
        #1 fir_done = 1'b1;
        @(posedge sys_clk);
        #1 fir_done = 1'b0;
        if (bp_req_n != bp_used) begin
          bp_used = bp_req_n;
          bp_go_n++;
        end
      end
    end
  end

  // Output buffer readiness
  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (bp_go_n != bp_seen) begin
        bp_seen = bp_go_n;
        bp_cnt = 7;
      end
      if (bp_cnt > 0) begin
        out_ready = 1'b0;
        bp_cnt--;
      end else if (rdy_all) out_ready = 1'b1;
      else out_ready = ($urandom_range(3) != 0);
    end
  end

  // Overlap copy counter model
  initial begin
    forever begin
      @(negedge sys_clk);
      if (reset && in_copy) begin
        repeat ($urandom_range(0, 4)) @(posedge sys_clk);
        @(posedge sys_clk);
        #1 in_copy_end = 1'b1;
        @(posedge sys_clk);
        #1 in_copy_end = 1'b0;
      end
    end
  end

  // Monitor
  fir_t me;
  bit pend = 1'b0;
  bit prev_cend = 1'b0;
  int wr_run = 0;
  int last_cyc = 0;
  int last_ph = 0;
  int last_base = 0;

  always @(negedge sys_clk) begin
    if (!reset) begin
      pend = 1'b0;
      wr_run = 0;
      prev_cend = 1'b0;
    end else begin
      if (pend) chk("wr_held", out_wr, 1);
      if (fir_start) begin
        if (out_wr || in_copy) bad("start_overlap");
        if (exp_fir.size() == 0) bad("fir_extra");
        else begin
          me = exp_fir.pop_front();
          chk("fir_phase", fir_phase, me.ph);
          chk("fir_base", fir_base, me.base);
          if (gap_en && me.k > 0)
            chk("start_gap", cyc - last_cyc,
                3 + lat_fix + (last_ph + D) / I);
          last_cyc = cyc;
          last_ph = me.ph;
          last_base = fir_base;
        end
      end
      wr_run = out_wr ? wr_run + 1 : 0;
      if (out_wr && out_ready) begin
        if (exp_cnt.size() == 0) bad("wr_extra");
        else chk("out_count", out_count, exp_cnt.pop_front());
        if (bp_go_n != bp_done_n) begin
          chk("bp_wr_cycles", wr_run, 8);
          bp_done_n = bp_go_n;
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) bad("done_extra");
        else void'(exp_done.pop_front());
        chk("copy_end_before_done", prev_cend, 1);
        chk("fir_total", exp_fir.size(), 0);
        chk("wr_total", exp_cnt.size(), 0);
        chk("final_count", out_count, N);
        chk("final_base", last_base, 766);
        chk("done_busy", busy, 1);
        frames++;
      end
      pend = out_wr && !out_ready;
      prev_cend = in_copy && in_copy_end;
    end
  end

  // Stimulus
  initial begin
    int oc;
    repeat (3) @(posedge sys_clk);
    #1 chk_zero("por");
    @(negedge sys_clk) reset = 1'b1;

    lat_fix = 5;
    rdy_all = 1'b1;
    gap_en = 1'b1;
    start_frame();
    wait_frame(1);
    post_checks();

    lat_fix = 0;
    rdy_all = 1'b0;
    gap_en = 1'b0;
    start_frame();
    wait_frame(2);
    post_checks();

    lat_fix = 5;
    rdy_all = 1'b1;
    start_frame();
    wait_start();
    wait_start();
    @(posedge sys_clk);
    #1 process_start = 1'b1;
    oc = out_count;
    @(posedge sys_clk);
    #1 process_start = 1'b0;
    @(negedge sys_clk);
    chk("ign_count", out_count, oc);
    chk("ign_busy", busy, 1);
`ifdef RSMP_OVERRUN_DET_EN
    chk("ovr_set", overrun, 1);
`endif
    bp_req_n++;
    wait_frame(3);
    post_checks();
`ifdef RSMP_OVERRUN_DET_EN
    chk("ovr_sticky", overrun, 1);
`endif

    gap_en = 1'b1;
    start_frame();
`ifdef RSMP_OVERRUN_DET_EN
    @(negedge sys_clk);
    chk("ovr_clear", overrun, 0);
`endif
    wait_start();
    wait_start();
    @(posedge sys_clk);
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    exp_fir.delete();
    exp_cnt.delete();
    exp_done.delete();
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b1;
    repeat (60) @(negedge sys_clk);
    chk("rst_no_done", frames, 3);
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_count", out_count, 0);
    finish_run();
  end

endmodule
